serial_subtractor: RTL

- Bit-serial N-bit subtractor: computes Diff = A − B − Bin using one full-subtractor cell plus a borrow flop, one bit per clock, LSB first.
- Area-reduced counterpart to the parallel carry-chain adders in the ADDERS examples: ripple borrow instead of ripple carry, unrolled in time instead of in space.
- Operands are loaded via a start/done handshake. The result is held stable until the next operation completes.

---
 rtl/serial_subtractor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit subtractor: Diff = (A - B - Bin) mod 2^N.
//   A single full-subtractor cell and a borrow flop process one bit per clock,
//   LSB first. Operands are captured on an accepted start. The result is
//   registered and held until the next operation completes.
//
//   Optional feature (macro SERIAL_SUB_OVF_EN): adds a registered Ovf output,
//   the two's-complement overflow flag of A - B - Bin. Ovf updates together
//   with Diff.
//
// Ports
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous, active-high reset
//   start  in   1   load request, honoured only in IDLE or DONE
//   A      in   N   minuend, captured on accepted start
//   B      in   N   subtrahend, captured on accepted start
//   Bin    in   1   borrow-in, captured on accepted start
//   busy   out  1   high while bits are being shifted
//   done   out  1   one-cycle pulse: Diff/Bout just updated
//   Diff   out  N   registered difference
//   Ovf    out  1   registered signed overflow (SERIAL_SUB_OVF_EN only)
//   Bout   out  1   registered borrow-out (1 means unsigned A < B + Bin)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic         Ovf,
`endif
    output logic         Bout
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    sa_q, sa_d;
    logic [N-1:0]    sb_q, sb_d;
    // Only N-1 partial bits need storing: the final bit goes straight into Diff.
    logic [N-2:0]    sd_q, sd_d;
    logic            br_q, br_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic [1:0]      msb_q, msb_d;   // {A[N-1], B[N-1]} of the operation in flight
    logic            ovf_q, ovf_d;
`endif

    // Full-subtractor cell operating on the current LSBs.
    logic            bit_a, bit_b, bit_d, br_new;
    logic [N-1:0]    sd_shift;
    logic            load;

    assign bit_a    = sa_q[0];
    assign bit_b    = sb_q[0];
    assign bit_d    = bit_a ^ bit_b ^ br_q;
    assign br_new   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    assign sd_shift = {bit_d, sd_q};

    // start is accepted only when no operation is in flight.
    assign load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        msb_d   = msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_SHIFT: begin
                sa_d  = {1'b0, sa_q[N-1:1]};
                sb_d  = {1'b0, sb_q[N-1:1]};
                sd_d  = sd_shift[N-1:1];
                br_d  = br_new;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = sd_shift;
                    bout_d  = br_new;
`ifdef SERIAL_SUB_OVF_EN
                    // bit_d is the result MSB on the last shift.
                    ovf_d   = (msb_q[1] ^ msb_q[0]) & (msb_q[1] ^ bit_d);
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Loading from DONE gives back-to-back operation without an IDLE bubble.
        if (load) begin
            sa_d    = A;
            sb_d    = B;
            br_d    = Bin;
            cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
            msb_d   = {A[N-1], B[N-1]};
`endif
            state_d = S_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            msb_q   <= 2'b00;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            msb_q   <= msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule
